md_ctrl: RTL and testbench
==========================

# md_ctrl

Multiply/divide sequencer for the five-stage pipeline. It owns the HI/LO registers and runs a fixed-latency busy counter for mult/div. It also raises the stall request that holds an md-type instruction in the decode stage while an operation is in flight. It sits beside the execute-stage ALU; the stage register in front of it supplies op and operands, and the hazard unit consumes `stall_md`.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (and madd family).
- `DIV_CYCLES`, default 10: busy cycles for div/divu.
- `clk` input, 1 bit: single clock, all state on rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `start` input, 1 bit: execute-stage instruction is mult/multu/div/divu (or madd family); one-cycle pulse.
- `md_op` input, 4 bits: operation code (`md_op_t` from package).
- `wr_hi` input, 1 bit: execute-stage mthi.
- `wr_lo` input, 1 bit: execute-stage mtlo.
- `rs_val` input, 32 bits: forwarded rs operand.
- `rt_val` input, 32 bits: forwarded rt operand.
- `md_use_D` input, 1 bit: decode-stage instruction is mult/div/mfhi/mflo/mthi/mtlo (or madd family).
- `busy` output, 1 bit: operation in flight.
- `stall_md` output, 1 bit: stall request to the hazard unit.
- `hi` output, 32 bits: HI register.
- `lo` output, 32 bits: LO register.

## Operation
- FSM with two states, IDLE and BUSY. A down-counter is sized `$clog2(max(MULT_CYCLES,DIV_CYCLES)+1)` bits.
- Accepting an operation (IDLE with `start`=1):
  - Latch the result into staging registers `hi_n`/`lo_n`.
  - Load the counter with the op's cycle count.
  - Go to BUSY.
- Leaving BUSY:
  - Decrement the counter each cycle.
  - When the counter reaches 1, commit `hi_n`/`lo_n` to `hi`/`lo` and return to IDLE.
- Result arithmetic:
  - mult: signed 32×32→64. multu: unsigned. HI takes the upper word, LO the lower word.
  - div: signed. LO = quotient, HI = remainder, with the remainder's sign following the dividend. divu: unsigned.
  - Division by zero gives HI = `rs_val`, LO = 32'hFFFF_FFFF. No exception is raised.
  - Signed overflow (0x80000000 / -1) gives LO = 0x80000000, HI = 0.
- mthi/mtlo:
  - Valid only in IDLE. The write takes effect at the next edge with no busy period.
  - If `wr_hi`/`wr_lo` coincides with `start`, `start` wins and the move is ignored.
  - Ignored in BUSY.
- `start` in BUSY is ignored and does not restart the operation; the hazard unit's stall must prevent it.
- `stall_md` = (`busy` | `start`) & `md_use_D`. Combinational.
- Undefined `md_op` with `start`: treated as no-op and the block stays IDLE.

## Timing
- Reset values: `busy`=0, `stall_md`=0 when `md_use_D`=0, `hi`=0, `lo`=0, counter=0, state IDLE.
- Latency:
  - `start` sampled at edge t.
  - `busy`=1 from t through t+N−1 (N cycles).
  - `hi`/`lo` update at edge t+N and `busy`=0 after t+N.
  - Old `hi`/`lo` stay visible throughout the busy period.
- mthi/mtlo sampled at edge t gives `hi`/`lo` new value after t.
- Reset mid-operation: state goes to IDLE, `busy` drops after the reset edge, staging registers are discarded, and `hi`/`lo` = 0.
- Back-to-back: a new `start` is accepted in the first cycle after `busy` falls.

## Configuration
- `MD_MADD_EN`
  - Defined: madd/maddu/msub/msubu codes are decoded, with MULT_CYCLES latency. The result is {hi,lo} ± product (64-bit, wraps mod 2^64) using `hi`/`lo` sampled at start.
  - Undefined: those codes are treated as undefined (no-op), and the accumulate adder is not synthesized.

## Structure
- Package `md_pkg`:
  - `md_op_t` enum: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, NONE.
  - Cycle-count defaults.
- Optional sub-module `md_calc`: combinational 64-bit result generation from op and operands.
- The FSM and counter stay in `md_ctrl`.

## Test plan
- Reset, then mult with rs=0xFFFFFFFE (−2), rt=3:
  - busy stays high for 5 cycles.
  - hi=0xFFFFFFFF, lo=0xFFFFFFFA appear after edge t+5, with hi/lo=0 during busy.
- divu with rs=7, rt=2: after 10 cycles, lo=3, hi=1. div with rs=−7, rt=2 gives lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div by zero with rs=0x1234: hi=0x1234, lo=0xFFFFFFFF. div 0x80000000/−1: lo=0x80000000, hi=0.
- mthi 0xAA during busy is ignored. The same mthi after busy falls gives hi=0xAA next cycle. `md_use_D`=1 during busy gives `stall_md`=1.
- Reset asserted at cycle 3 of a div: busy=0, hi=lo=0 next cycle, and no later commit.
- With `MD_MADD_EN`: start from hi=0, lo=0xFFFFFFFF and run madd with 1×1. The result is hi=1, lo=0.

Source files
------------

// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg
// Shared types and constants for the multiply/divide sequencer.
//   md_op_t     : operation codes carried on md_op
//   md_state_t  : sequencer FSM states
//   MD_*_CYCLES : default busy-period lengths
//   md_is_div() : selects the division latency for an op code
// -----------------------------------------------------------------------------
package md_pkg;

  localparam int MD_OP_W         = 4;
  localparam int MD_MULT_CYCLES  = 5;
  localparam int MD_DIV_CYCLES   = 10;

  typedef enum logic [MD_OP_W-1:0] {
    MULT  = 4'd0,
    MULTU = 4'd1,
    DIV   = 4'd2,
    DIVU  = 4'd3,
    MADD  = 4'd4,
    MADDU = 4'd5,
    MSUB  = 4'd6,
    MSUBU = 4'd7,
    NONE  = 4'd8
  } md_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_t;

  function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/md_if.sv
// -----------------------------------------------------------------------------
// md_if
// Execute-stage request bus and result/status bus of the multiply/divide unit.
//   master : pipeline side (drives start/md_op/wr_hi/wr_lo/rs_val/rt_val/md_use_D)
//   slave  : md_ctrl side  (drives busy/stall_md/hi/lo)
// -----------------------------------------------------------------------------
interface md_if ();

  logic                        start;
  logic [md_pkg::MD_OP_W-1:0]  md_op;
  logic                        wr_hi;
  logic                        wr_lo;
  logic [31:0]                 rs_val;
  logic [31:0]                 rt_val;
  logic                        md_use_D;
  logic                        busy;
  logic                        stall_md;
  logic [31:0]                 hi;
  logic [31:0]                 lo;

  modport master (
    output start, md_op, wr_hi, wr_lo, rs_val, rt_val, md_use_D,
    input  busy, stall_md, hi, lo
  );

  modport slave (
    input  start, md_op, wr_hi, wr_lo, rs_val, rt_val, md_use_D,
    output busy, stall_md, hi, lo
  );

endinterface

// File: rtl/md_calc.sv
// -----------------------------------------------------------------------------
// md_calc
// Combinational 64-bit result generator; output is {HI, LO}.
//   i_op      : operation code (md_op_t encoding, undefined codes allowed)
//   i_rs/i_rt : operands
//   i_hi/i_lo : current HI/LO, accumulate source (only with MD_MADD_EN)
//   o_valid   : i_op is an operation this build implements
//   o_result  : {HI, LO} that the operation produces
// Build option: MD_MADD_EN adds madd/maddu/msub/msubu and the accumulate adder.
// -----------------------------------------------------------------------------
module md_calc
  import md_pkg::*;
(
  input  logic [MD_OP_W-1:0] i_op,
  input  logic [31:0]        i_rs,
  input  logic [31:0]        i_rt,
`ifdef MD_MADD_EN
  input  logic [31:0]        i_hi,
  input  logic [31:0]        i_lo,
`endif
  output logic               o_valid,
  output logic [63:0]        o_result
);

  // Products: the low 64 bits of a sign-extended 64x64 multiply are the
  // exact signed 32x32 product.
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;

  assign w_prod_s = {{32{i_rs[31]}}, i_rs} * {{32{i_rt[31]}}, i_rt};
  assign w_prod_u = {32'b0, i_rs} * {32'b0, i_rt};

  // One unsigned divider serves both div and divu: signed division divides
  // magnitudes, then the quotient takes the XOR of the signs and the
  // remainder the dividend's sign. 0x80000000 / -1 falls out as
  // quotient 0x80000000, remainder 0 without a special case.
  logic        w_div_signed;
  logic [31:0] w_dvd;
  logic [31:0] w_dvs;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_q;
  logic [31:0] w_r;

  assign w_div_signed = (i_op == DIV);
  assign w_dvd = (w_div_signed && i_rs[31]) ? -i_rs : i_rs;
  assign w_dvs = (w_div_signed && i_rt[31]) ? -i_rt : i_rt;
  assign w_uq  = w_dvd / w_dvs;
  assign w_ur  = w_dvd % w_dvs;
  assign w_q   = (w_div_signed && (i_rs[31] ^ i_rt[31])) ? -w_uq : w_uq;
  assign w_r   = (w_div_signed && i_rs[31]) ? -w_ur : w_ur;

`ifdef MD_MADD_EN
  logic [63:0] w_acc_prod;
  logic [63:0] w_acc;

  assign w_acc_prod = ((i_op == MADD) || (i_op == MSUB)) ? w_prod_s : w_prod_u;
  assign w_acc      = ((i_op == MSUB) || (i_op == MSUBU))
                      ? ({i_hi, i_lo} - w_acc_prod)
                      : ({i_hi, i_lo} + w_acc_prod);
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a value unassigned, which would infer a latch.
    o_valid  = 1'b0;
    o_result = '0;
    case (i_op)
      MULT:  begin o_valid = 1'b1; o_result = w_prod_s; end
      MULTU: begin o_valid = 1'b1; o_result = w_prod_u; end
      DIV, DIVU: begin
        o_valid = 1'b1;
        // Divide by zero: HI keeps the dividend, LO saturates to all ones.
        if (i_rt == '0) o_result = {i_rs, 32'hFFFF_FFFF};
        else            o_result = {w_r, w_q};
      end
`ifdef MD_MADD_EN
      MADD, MADDU, MSUB, MSUBU: begin o_valid = 1'b1; o_result = w_acc; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// -----------------------------------------------------------------------------
// md_ctrl
// Multiply/divide sequencer beside the execute-stage ALU. Owns HI/LO, runs a
// fixed-latency busy period per operation and raises the decode-stage stall.
//   clk   : clock, all state on the rising edge
//   reset : synchronous, active-high
//   bus   : md_if.slave
//             in : start, md_op, wr_hi, wr_lo, rs_val, rt_val, md_use_D
//             out: busy, stall_md, hi, lo
// Parameters: MULT_CYCLES (mult family latency), DIV_CYCLES (div latency).
// Build option: MD_MADD_EN enables the madd/msub family (see md_calc).
// -----------------------------------------------------------------------------
module md_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
)(
  input  logic clk,
  input  logic reset,
  md_if.slave  bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_t   r_state;
  md_state_t   w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_load_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_hi_n;
  logic [31:0] r_lo_n;

  logic        w_valid;
  logic [63:0] w_result;
  logic        w_load;
  logic        w_commit;
  logic        w_move_ok;

  md_calc u_calc (
    .i_op     (bus.md_op),
    .i_rs     (bus.rs_val),
    .i_rt     (bus.rt_val),
`ifdef MD_MADD_EN
    .i_hi     (r_hi),
    .i_lo     (r_lo),
`endif
    .o_valid  (w_valid),
    .o_result (w_result)
  );

  assign w_load_cnt = md_is_div(bus.md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  // mthi/mtlo only land in IDLE, and a coinciding start takes priority.
  assign w_move_ok = (r_state == S_IDLE) && !bus.start;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Undefined op codes are a no-op: no load, stay IDLE.
        if (bus.start && w_valid) begin
          w_load      = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt == CNT_W'(1)) begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the staging registers are reset too, so an operation aborted by
      // reset leaves nothing that a later commit could pick up.
      r_cnt  <= '0;
      r_hi_n <= '0;
      r_lo_n <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      if (w_load) begin
        r_cnt  <= w_load_cnt;
        r_hi_n <= w_result[63:32];
        r_lo_n <= w_result[31:0];
      end else if (r_state == S_BUSY) begin
        r_cnt  <= r_cnt - CNT_W'(1);
      end

      // Old HI/LO stay visible for the whole busy period.
      if (w_commit) begin
        r_hi <= r_hi_n;
        r_lo <= r_lo_n;
      end else if (w_move_ok) begin
        if (bus.wr_hi) r_hi <= bus.rs_val;
        if (bus.wr_lo) r_lo <= bus.rs_val;
      end
    end
  end

  assign bus.busy     = (r_state == S_BUSY);
  assign bus.stall_md = ((r_state == S_BUSY) || bus.start) && bus.md_use_D;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;

endmodule

// File: tb/tb_md_ctrl.sv
// -----------------------------------------------------------------------------
// tb_md_ctrl
// Self-checking bench for md_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized operations against a reference model.
// -----------------------------------------------------------------------------
module tb_md_ctrl;
  import md_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_if bus ();

  md_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Architectural HI/LO as the bench expects them.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cycles;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: results computed from the arithmetic rules with 64-bit ints.
  function automatic bit ref_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                input logic [31:0] hi, input logic [31:0] lo,
                                output logic [31:0] nh, output logic [31:0] nl, output int n);
    longint          sa, sb, q, rm;
    longint unsigned ua, ub;
    logic [63:0]     r;
    bit              ok;
    sa = $signed(rs);
    sb = $signed(rt);
    ua = {32'b0, rs};
    ub = {32'b0, rt};
    ok = 1'b1;
    r  = '0;
    n  = MULT_N;
    case (op)
      MULT:  r = sa * sb;
      MULTU: r = ua * ub;
      DIV: begin
        n = DIV_N;
        if (rt == 0) r = {rs, 32'hFFFF_FFFF};
        else begin
          q  = sa / sb;
          rm = sa % sb;
          r  = {rm[31:0], q[31:0]};
        end
      end
      DIVU: begin
        n = DIV_N;
        if (rt == 0) r = {rs, 32'hFFFF_FFFF};
        else begin
          q  = ua / ub;
          rm = ua % ub;
          r  = {rm[31:0], q[31:0]};
        end
      end
`ifdef MD_MADD_EN
      MADD:  r = {hi, lo} + sa * sb;
      MADDU: r = {hi, lo} + ua * ub;
      MSUB:  r = {hi, lo} - sa * sb;
      MSUBU: r = {hi, lo} - ua * ub;
`endif
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      r = {hi, lo};
      n = 0;
    end
    nh = r[63:32];
    nl = r[31:0];
    return ok;
  endfunction

  // Issues one start pulse and follows it through the busy period.
  // n == 0 means the op must be ignored.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] eh, input logic [31:0] el,
                        input int n);
    bus.start    = 1'b1;
    bus.md_op    = op;
    bus.rs_val   = rs;
    bus.rt_val   = rt;
    bus.md_use_D = 1'b1;
    #1;
    check({name, " stall_on_start"}, bus.stall_md, 1'b1);
    step();
    bus.start    = 1'b0;
    bus.md_use_D = 1'b0;
    if (n == 0) begin
      check({name, " ignored"}, {bus.busy, bus.hi, bus.lo}, {1'b0, m_hi, m_lo});
      return;
    end
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s busy_cycle%0d", name, k), {bus.busy, bus.hi, bus.lo}, {1'b1, m_hi, m_lo});
      step();
    end
    check({name, " commit"}, {bus.busy, bus.hi, bus.lo}, {1'b0, eh, el});
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic move(input string name, input bit h, input bit l, input logic [31:0] v);
    bus.wr_hi  = h;
    bus.wr_lo  = l;
    bus.rs_val = v;
    step();
    bus.wr_hi  = 1'b0;
    bus.wr_lo  = 1'b0;
    if (h) m_hi = v;
    if (l) m_lo = v;
    check(name, {bus.busy, bus.hi, bus.lo}, {1'b0, m_hi, m_lo});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] eh, el, rs, rt;
    int          n;
    logic [3:0]  op;
    bit          ok;

    bus.start = 0; bus.md_op = '0; bus.wr_hi = 0; bus.wr_lo = 0;
    bus.rs_val = '0; bus.rt_val = '0; bus.md_use_D = 0;

    // ---------------- reset state ----------------
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("reset_state", {bus.busy, bus.stall_md, bus.hi, bus.lo}, '0);
    bus.md_use_D = 1'b1;
    #1;
    check("idle_no_stall", bus.stall_md, 1'b0);
    bus.md_use_D = 1'b0;
    step();

    // ---------------- directed vector table ----------------
    vecs.push_back('{"mult_m2x3",    MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, MULT_N});
    vecs.push_back('{"divu_7_2",     DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         DIV_N});
    vecs.push_back('{"div_m7_2",     DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N});
    vecs.push_back('{"div_7_m2",     DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, DIV_N});
    vecs.push_back('{"div_by_zero",  DIV,   32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, DIV_N});
    vecs.push_back('{"divu_by_zero", DIVU,  32'd0,         32'd0,         32'd0,         32'hFFFF_FFFF, DIV_N});
    vecs.push_back('{"div_overflow", DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, DIV_N});
    vecs.push_back('{"multu_max",    MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MULT_N});
    vecs.push_back('{"mult_min_sq",  MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MULT_N});
    vecs.push_back('{"undef_op",     4'hC,  32'd5,         32'd6,         32'h4000_0000, 32'h0000_0000, 0});
    vecs.push_back('{"none_op",      NONE,  32'd5,         32'd6,         32'h4000_0000, 32'h0000_0000, 0});
    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].cycles);

    // ---------------- mthi during busy, then after ----------------
    bus.start = 1'b1; bus.md_op = DIV; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < DIV_N; k++) begin
      if (k == 2) begin
        bus.wr_hi = 1'b1; bus.rs_val = 32'hAA; bus.md_use_D = 1'b1;
        #1;
        check("stall_during_busy", bus.stall_md, 1'b1);
      end
      check($sformatf("mthi_busy cycle%0d", k), {bus.busy, bus.hi, bus.lo}, {1'b1, m_hi, m_lo});
      step();
      bus.wr_hi = 1'b0; bus.md_use_D = 1'b0;
    end
    m_hi = 32'd2; m_lo = 32'd14;
    check("mthi_busy_ignored", {bus.busy, bus.hi, bus.lo}, {1'b0, m_hi, m_lo});
    move("mthi_after_busy", 1'b1, 1'b0, 32'hAA);
    move("mtlo_idle", 1'b0, 1'b1, 32'h5555_0001);

    // start wins over a coinciding mtlo
    bus.wr_lo = 1'b1;
    run_op("start_beats_mtlo", MULTU, 32'd2, 32'd3, 32'd0, 32'd6, MULT_N);
    bus.wr_lo = 1'b0;

    // ---------------- reset in the middle of a div ----------------
    move("pre_reset_hi", 1'b1, 1'b0, 32'hDEAD_BEEF);
    bus.start = 1'b1; bus.md_op = DIV; bus.rs_val = 32'd9; bus.rt_val = 32'd4;
    step();
    bus.start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check("reset_mid_op", {bus.busy, bus.hi, bus.lo}, '0);
    for (int k = 0; k < DIV_N + 2; k++) step();
    check("no_commit_after_reset", {bus.busy, bus.hi, bus.lo}, '0);

    // ---------------- accumulate family ----------------
    move("madd_setup_hi", 1'b1, 1'b0, 32'd0);
    move("madd_setup_lo", 1'b0, 1'b1, 32'hFFFF_FFFF);
`ifdef MD_MADD_EN
    run_op("madd_carry", MADD, 32'd1, 32'd1, 32'd1, 32'd0, MULT_N);
`else
    run_op("madd_disabled", MADD, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 0);
`endif

    // ---------------- randomized, back-to-back ----------------
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 9))
        0: op = MULT;  1: op = MULTU; 2: op = DIV;   3: op = DIVU;
        4: op = MADD;  5: op = MADDU; 6: op = MSUB;  7: op = MSUBU;
        8: op = NONE;  default: op = 4'(9 + $urandom_range(0, 6));
      endcase
      rs = $urandom();
      rt = $urandom();
      case ($urandom_range(0, 7))
        0: rt = '0;
        1: begin rs = 32'h8000_0000; rt = 32'hFFFF_FFFF; end
        2: rt = 32'($urandom_range(1, 9));
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0)
        move($sformatf("rand_move%0d", i), 1'($urandom_range(0, 1)), 1'b1, $urandom());
      ok = ref_op(op, rs, rt, m_hi, m_lo, eh, el, n);
      run_op($sformatf("rand%0d_op%0d", i, op), op, rs, rt, eh, el, ok ? n : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
